// File: rtl/wb_boot_loader.sv
// Wishbone classic write master that loads a program image from a byte stream.
// Stream format: 4-byte little-endian word count N, then N little-endian words.
// Each word becomes one single-beat write at BASE_ADDR + 4*idx. The CPU is held
// in reset until the image is completely written.
module wb_boot_loader #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           MAX_WORDS      = 1024,
  parameter int unsigned           TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  output logic [3:0]            wbm_sel_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic                  core_hold_o,
  output logic                  done_o,
  output logic                  error_o
);

  // idx and length must be able to hold MAX_WORDS itself.
  localparam int unsigned IdxW = $clog2(MAX_WORDS + 1);
  // Timeout counter only needs to reach TIMEOUT_CYCLES-1 before firing.
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StLen,
    StCollect,
    StWrite,
    StDone,
    StError
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [31:0]             word_q, word_d;
  logic [IdxW-1:0]         len_q, len_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [31:0]             dat_q, dat_d;
  logic                    cyc_q, cyc_d;

  logic                    rx_state;
  logic                    take;
  logic [31:0]             assembled;

  assign rx_state = (state_q == StLen) || (state_q == StCollect);
  assign take     = byte_valid_i && rx_state;

  // Current partial word with the incoming byte dropped into its lane.
  always_comb begin
    assembled = word_q;
    assembled[{cnt_q, 3'b000} +: 8] = byte_data_i;
  end

  // Next-state logic: byte gathering, length check and write termination.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    adr_d   = adr_q;
    dat_d   = dat_q;

    unique case (state_q)
      StLen: begin
        if (take) begin
          cnt_d  = cnt_q + 2'd1;
          word_d = assembled;
          if (cnt_q == 2'd3) begin
            if (assembled == 32'd0) begin
              state_d = StDone;
            end else if (assembled > 32'(MAX_WORDS)) begin
              state_d = StError;
            end else begin
              len_d   = IdxW'(assembled);
              idx_d   = '0;
              state_d = StCollect;
            end
          end
        end
      end
      StCollect: begin
        if (take) begin
          cnt_d  = cnt_q + 2'd1;
          word_d = assembled;
          if (cnt_q == 2'd3) begin
            adr_d   = BASE_ADDR + (ADDR_WIDTH'(idx_q) << 2);
            dat_d   = assembled;
            tmo_d   = '0;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (wbm_err_i) begin
          state_d = StError;
        end else if (wbm_ack_i) begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q + 1'b1 == len_q) ? StDone : StCollect;
        end else if (tmo_q == TmoLast) begin
          state_d = StError;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StError;
    endcase

    cyc_d = (state_d == StWrite);
  end

  // State and datapath registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StLen;
      cnt_q   <= '0;
      word_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
    end
  end

  // Ready is masked while reset is held so every output reads 0 during reset.
  assign byte_ready_o = rx_state && !reset_i;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = cyc_q;
  assign wbm_sel_o    = {4{cyc_q}};
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign core_hold_o  = (state_q != StDone);
  assign done_o       = (state_q == StDone);
  assign error_o      = (state_q == StError);

endmodule

// File: doc/wb_boot_loader.md
Name: wb_boot_loader

Overview:
- Wishbone classic master that writes a program image into the shared instruction/data memory of barebones_wb_top.
- It is the hardware writer for that memory, replacing the simulation-only hex preload.
- It receives a byte stream over a valid/ready interface, packs the bytes into 32-bit little-endian words, and issues one single-beat Wishbone write per word.
- It holds the core in reset until the whole image is written.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- BASE_ADDR, 32'h0000_0000, byte address where word 0 is written.
- MAX_WORDS, 1024, largest accepted image length in words.
- TIMEOUT_CYCLES, 255, number of cycles a write may wait for ack before the block errors out.

Ports:
- clk_i, input, 1, system clock.
- reset_i, input, 1, asynchronous active-high reset.
- byte_valid_i, input, 1, stream byte valid.
- byte_data_i, input, 8, stream byte.
- byte_ready_o, output, 1, loader can accept a byte.
- wbm_cyc_o, output, 1, Wishbone cycle.
- wbm_stb_o, output, 1, Wishbone strobe.
- wbm_we_o, output, 1, write enable; always 1 when stb is high.
- wbm_adr_o, output, ADDR_WIDTH, byte address.
- wbm_dat_o, output, 32, write data.
- wbm_sel_o, output, 4, byte selects.
- wbm_ack_i, input, 1, slave acknowledge.
- wbm_err_i, input, 1, slave error.
- core_hold_o, output, 1, 1 = keep the CPU in reset.
- done_o, output, 1, image fully written (sticky).
- error_o, output, 1, load failed (sticky).

Behaviour:
- Clock and reset: single clock clk_i. reset_i is asynchronous and active-high.
- Reset values: all outputs are 0 except core_hold_o = 1. Reset is asynchronous, so a reset asserted mid-write drops cyc/stb immediately.
- States:
  - LEN: accept 4 length bytes.
  - COLLECT: accept 4 data bytes.
  - WRITE: Wishbone write in progress.
  - DONE: terminal success.
  - ERROR: terminal failure.
- After reset release the block enters LEN with byte_ready_o = 1.
- Byte transfer: a byte is taken on a rising edge where byte_valid_i & byte_ready_o. byte_ready_o is 1 only in LEN and COLLECT; it never depends combinationally on byte_valid_i.
- Packing: the first byte of a group goes to bits [7:0], the fourth to bits [31:24].
- LEN exit, after the 4th byte (length N):
  - N == 0 -> DONE.
  - N > MAX_WORDS -> ERROR.
  - Otherwise -> COLLECT, word index idx = 0.
- COLLECT -> WRITE on the edge that accepts the 4th byte. From the next cycle:
  - cyc = stb = we = 1, sel = 4'hF.
  - adr = BASE_ADDR + (idx << 2), truncated to ADDR_WIDTH (wraps).
  - dat = packed word.
- Outputs are registered and held stable until the cycle is terminated.
- WRITE termination:
  - err_i = 1 -> ERROR, with cyc/stb low the next cycle. err has priority when ack and err are high together.
  - ack_i = 1 -> cyc/stb low the next cycle and idx increments. If idx+1 == N -> DONE, else -> COLLECT.
  - No termination: a timeout counter (cleared on WRITE entry) increments each WRITE cycle. When it reaches TIMEOUT_CYCLES -> ERROR with cyc/stb dropped.
- Minimum cost: 5 cycles per word (4 byte cycles + 1 ack cycle) with a zero-wait slave.
- Spurious responses: ack/err outside WRITE are ignored.
- DONE: done_o = 1, core_hold_o = 0, byte_ready_o = 0. Further bytes are ignored. Held until reset.
- ERROR: error_o = 1, core_hold_o = 1, byte_ready_o = 0. Held until reset.
- done_o and error_o are never both 1.
- Stall tolerance: byte_valid_i low for any number of cycles stalls the block with no state change and no timeout counting.

Test Plan:
- Happy path: stream length 2 (bytes 02 00 00 00), then bytes 13 00 50 00 and 93 00 A0 00.
  - Write 1: adr 0x0, dat 0x00500013, sel F.
  - Write 2: adr 0x4, dat 0x00A00093.
  - Then done_o = 1 and core_hold_o falls to 0.
- Zero-length image: stream 00 00 00 00 -> no Wishbone cycle, done_o = 1 one cycle after the 4th byte.
- Oversize length: stream length MAX_WORDS+1 -> error_o = 1, byte_ready_o = 0, core_hold_o stays 1, no cyc asserted.
- Slave wait and timeout:
  - Slave delays ack by 7 cycles -> cyc/stb/adr/dat stay stable for all 7 cycles; write completes.
  - Slave never acks -> error_o rises after TIMEOUT_CYCLES cycles and cyc drops.
- Err/ack collision: wbm_err_i and wbm_ack_i high on the same cycle -> ERROR, idx not incremented, done_o stays 0.
- Reset mid-write: assert reset_i while cyc = 1 -> cyc/stb drop without waiting for a clock edge.
  - After release the block is back in LEN with core_hold_o = 1.
  - A fresh image loads correctly from BASE_ADDR.
